cycle_cooling_system: RTL and testbench



---
 rtl/cycle_cooling_system.sv | 99 +++++++++
 tb/tb_cycle_cooling_system.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/cycle_cooling_system.sv
// Rider-cooling fan controller: immediate turn-on, delayed turn-off.
//
// state  | meaning
// -------+----------------------------------------------------------
// S_OFF  | fan off, waiting for cooling demand
// S_ON   | demand present, fan on
// S_HOLD | demand gone, fan kept on while the hold counter runs down
module cycle_cooling_system #(
    parameter int CAL_TH      = 2,
    parameter int TEMP_TH     = 3,
    parameter int HOLD_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] calorie,
    input  logic [2:0] temperature,
    input  logic       pressure,
    input  logic       air_pressure,
    output logic       fan
);

    localparam int CW          = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam int HOLD_LOAD_I = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;

    localparam logic [2:0]    CAL_TH_L  = 3'(CAL_TH);
    localparam logic [2:0]    TEMP_TH_L = 3'(TEMP_TH);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_LOAD_I);

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_ON   = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          demand;

    // Cooling demand from sensor levels; either pressure flag alone is ignored.
    always_comb begin
        demand = (calorie >= CAL_TH_L)
               | (temperature >= TEMP_TH_L)
               | (pressure & air_pressure);
    end

    // Next-state and hold-counter logic; demand wins over hold expiry.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_OFF: begin
                if (demand) begin
                    state_nxt = S_ON;
                end
            end
            S_ON: begin
                if (!demand) begin
                    if (HOLD_CYCLES > 0) begin
                        state_nxt = S_HOLD;
                        cnt_nxt   = HOLD_LOAD;
                    end else begin
                        state_nxt = S_OFF;
                    end
                end
            end
            S_HOLD: begin
                if (demand) begin
                    state_nxt = S_ON;
                    cnt_nxt   = '0;
                end else if (cnt == '0) begin
                    state_nxt = S_OFF;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: begin
                state_nxt = S_OFF;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State, counter and fan registers; fan is decoded from the next state so
    // it changes on the same edge as the state it reflects.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_OFF;
            cnt   <= '0;
            fan   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            fan   <= (state_nxt != S_OFF);
        end
    end

endmodule

// File: tb/tb_cycle_cooling_system.sv
// Directed bench for cycle_cooling_system with default parameters
// (CAL_TH=2, TEMP_TH=3, HOLD_CYCLES=16).
module tb_cycle_cooling_system;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] calorie;
    logic [2:0] temperature;
    logic       pressure;
    logic       air_pressure;
    logic       fan;

    int errors = 0;
    int checks = 0;

    localparam int HOLD = 16;

    cycle_cooling_system dut (
        .clk          (clk),
        .reset        (reset),
        .calorie      (calorie),
        .temperature  (temperature),
        .pressure     (pressure),
        .air_pressure (air_pressure),
        .fan          (fan)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_fan(input string tag, input logic exp);
        checks++;
        assert (fan === exp)
        else begin
            errors++;
            $error("FAIL %s: fan=%b expected %b", tag, fan, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [4:0] exp);
        checks++;
        assert (dut.cnt === exp)
        else begin
            errors++;
            $error("FAIL %s: cnt=%0d expected %0d", tag, dut.cnt, exp);
        end
    endtask

    task automatic set_in(input logic [2:0] c, input logic [2:0] t,
                          input logic p, input logic ap);
        calorie      = c;
        temperature  = t;
        pressure     = p;
        air_pressure = ap;
    endtask

    initial begin
        // Reset held for two edges with maximum effort: fan must stay off.
        reset = 1'b1;
        set_in(3'd7, 3'd0, 1'b0, 1'b0);
        tick();
        chk_fan("reset_edge1", 1'b0);
        chk_cnt("reset_cnt", 5'd0);
        tick();
        chk_fan("reset_edge2", 1'b0);
        reset = 1'b0;
        tick();
        chk_fan("reset_release_on", 1'b1);

        // Clear back to OFF with no demand.
        reset = 1'b1;
        set_in(3'd0, 3'd0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        tick();
        chk_fan("idle_off", 1'b0);

        // Calorie at threshold (with pressure pair too): on after one edge, stays on.
        set_in(3'd2, 3'd2, 1'b1, 1'b1);
        tick();
        chk_fan("cal_trigger", 1'b1);
        for (int i = 0; i < 99; i++) begin
            tick();
            chk_fan("cal_stay_on", 1'b1);
        end

        // Just below both thresholds: 16 edges still on, off at edge 17.
        set_in(3'd1, 3'd2, 1'b0, 1'b0);
        for (int i = 1; i <= HOLD; i++) begin
            tick();
            chk_fan("hold_on", 1'b1);
        end
        tick();
        chk_fan("hold_expire", 1'b0);
        chk_cnt("hold_expire_cnt", 5'd0);
        for (int i = HOLD + 2; i <= 100; i++) begin
            tick();
            chk_fan("hold_stay_off", 1'b0);
        end

        // Pressure alone does nothing; pairing with airflow triggers.
        set_in(3'd0, 3'd0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_fan("pressure_alone", 1'b0);
        end
        set_in(3'd0, 3'd0, 1'b0, 1'b1);
        tick();
        chk_fan("air_alone", 1'b0);
        set_in(3'd0, 3'd0, 1'b1, 1'b1);
        tick();
        chk_fan("pressure_pair", 1'b1);

        // Re-trigger after 5 hold edges with temperature at threshold.
        set_in(3'd0, 3'd0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_fan("retrig_hold", 1'b1);
        end
        set_in(3'd0, 3'd3, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_fan("retrig_on", 1'b1);
        end
        chk_cnt("retrig_cnt_clear", 5'd0);
        // Full hold restarts from the beginning.
        set_in(3'd0, 3'd0, 1'b0, 1'b0);
        tick();
        chk_cnt("hold_load", 5'd15);
        chk_fan("restart_hold_1", 1'b1);
        for (int i = 2; i <= HOLD; i++) begin
            tick();
            chk_fan("restart_hold", 1'b1);
        end
        chk_cnt("hold_terminal", 5'd0);
        tick();
        chk_fan("restart_expire", 1'b0);

        // Demand arriving on the expiry edge keeps the fan on.
        set_in(3'd7, 3'd0, 1'b0, 1'b0);
        tick();
        chk_fan("prio_on", 1'b1);
        set_in(3'd0, 3'd0, 1'b0, 1'b0);
        for (int i = 1; i <= HOLD; i++) begin
            tick();
        end
        chk_fan("prio_last_hold", 1'b1);
        set_in(3'd0, 3'd7, 1'b0, 1'b0);
        tick();
        chk_fan("prio_demand_wins", 1'b1);
        tick();
        chk_fan("prio_still_on", 1'b1);

        // Reset on the 4th hold edge aborts the hold.
        set_in(3'd0, 3'd0, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk_fan("midhold_on", 1'b1);
        end
        reset = 1'b1;
        tick();
        chk_fan("midhold_reset", 1'b0);
        chk_cnt("midhold_cnt", 5'd0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk_fan("after_reset_off", 1'b0);
        end
        set_in(3'd3, 3'd0, 1'b0, 1'b0);
        tick();
        chk_fan("after_reset_on", 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
